// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: CHUNK bits per stage, skewed operands, de-skewed sum.
// A single global advance enable stalls every stage together under output back-pressure.

module rca_stage #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             vld_in,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  output logic             vld_out,
  output logic             c_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] s_out
);
  logic [CHUNK:0]   part;
  logic [WIDTH-1:0] s_nxt;

  assign part = {1'b0, a_in[IDX*CHUNK +: CHUNK]} + {1'b0, b_in[IDX*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_in};

  // Earlier chunks pass through untouched; this stage fills in its own slice.
  always_comb begin
    s_nxt = s_in;
    s_nxt[IDX*CHUNK +: CHUNK] = part[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out <= 1'b0;
      c_out   <= 1'b0;
      a_out   <= '0;
      b_out   <= '0;
      s_out   <= '0;
    end else if (adv) begin
      vld_out <= vld_in;
      c_out   <= part[CHUNK];
      a_out   <= a_in;
      b_out   <= b_in;
      s_out   <= s_nxt;
    end
  end
endmodule

module pipelined_rca #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CH_SAFE = (CHUNK > 0) ? CHUNK : 1;
  localparam int STAGES  = WIDTH / CH_SAFE;

  if ((CHUNK < 1) || (WIDTH < 1) || ((WIDTH % CH_SAFE) != 0)) begin : g_bad_params
    $error("pipelined_rca: WIDTH must be a positive multiple of a positive CHUNK");
  end

  logic                          adv;
  logic [STAGES:0]               vld_pipe;
  logic [STAGES:0]               c_pipe;
  logic [STAGES:0][WIDTH-1:0]    a_pipe;
  logic [STAGES:0][WIDTH-1:0]    b_pipe;
  logic [STAGES:0][WIDTH-1:0]    s_pipe;

  assign vld_pipe[0] = in_valid;
  assign c_pipe[0]   = cin;
  assign a_pipe[0]   = a;
  assign b_pipe[0]   = b;
  assign s_pipe[0]   = '0;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv),
      .vld_in  (vld_pipe[k]),
      .c_in    (c_pipe[k]),
      .a_in    (a_pipe[k]),
      .b_in    (b_pipe[k]),
      .s_in    (s_pipe[k]),
      .vld_out (vld_pipe[k+1]),
      .c_out   (c_pipe[k+1]),
      .a_out   (a_pipe[k+1]),
      .b_out   (b_pipe[k+1]),
      .s_out   (s_pipe[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign sum       = s_pipe[STAGES];
  assign cout      = c_pipe[STAGES];
  // Carry into the MSB recovered from the MSB's own sum bit: a ^ b ^ s.
  assign overflow  = c_pipe[STAGES] ^ a_pipe[STAGES][WIDTH-1]
                   ^ b_pipe[STAGES][WIDTH-1] ^ s_pipe[STAGES][WIDTH-1];
endmodule

// File: tb/tb_pipelined_rca.sv
// Directed and random checks of pipelined_rca (WIDTH=16, CHUNK=4, latency 4).
module tb_pipelined_rca;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        cin, in_valid, out_ready;
  logic        in_ready, cout, overflow, out_valid;
  logic [15:0] sum;
  logic [17:0] outs;
  logic [17:0] q[$];
  int          checks = 0;
  int          passes = 0;

  assign outs = {overflow, cout, sum};

  pipelined_rca #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .cout(cout), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] t;
    logic        ov;
    t  = {1'b0, x} + {1'b0, y} + {16'd0, c};
    ov = (x[15] == y[15]) && (t[15] != x[15]);
    return {ov, t[16], t[15:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (outs !== 18'd0) $display("FAIL reset_outputs: got %h expected 0", outs); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else passes++;
  endtask

  task automatic test_basic();
    logic [15:0] va [4] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000};
    logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h4321, 16'h8000};
    logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [17:0] ex [4] = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000},
                            {1'b0, 1'b0, 16'h5556}, {1'b1, 1'b1, 16'h0000}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; lat = 1;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      checks++; if (lat !== 4) $display("FAIL basic_latency[%0d]: got %0d expected 4", i, lat); else passes++;
      checks++; if (outs !== ex[i]) $display("FAIL basic_result[%0d]: got %h expected %h", i, outs, ex[i]); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] ex [8];
    logic [17:0] want;
    logic        want_v;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        want_v = (c >= 4) && (c < 12);
        want   = want_v ? ex[c-4] : 18'd0;
        checks++;
        if (out_valid !== want_v || (want_v && outs !== want))
          $display("FAIL b2b_cycle[%0d]: got v=%b %h expected v=%b %h", c, out_valid, outs, want_v, want);
        else passes++;
      end
      if (c < 8) begin
        a = 16'(c) * 16'h2345; b = 16'hFFFF - 16'(c); cin = c[0]; in_valid = 1'b1;
        ex[c] = model(a, b, cin);
      end else in_valid = 1'b0;
    end
  endtask

  task automatic test_stall();
    int          idx = 0;
    int          got = 0;
    logic [17:0] held = '0;
    q.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (idx < 8);
      a = 16'h0F00 + 16'(idx) * 16'h1111; b = 16'hF0F0 ^ 16'(idx); cin = idx[0];
      #1;
      if (c >= 5 && c <= 7) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b expected 0", c, in_ready); else passes++;
      end
      if (c == 5) held = outs;
      if (c == 6 || c == 7) begin
        checks++;
        if (out_valid !== 1'b1 || outs !== held)
          $display("FAIL stall_hold[%0d]: got v=%b %h expected v=1 %h", c, out_valid, outs, held);
        else passes++;
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || outs !== q[0]) $display("FAIL stall_result[%0d]: got %h expected %h", c, outs, (q.size() != 0) ? q[0] : 18'h0);
        else passes++;
        if (out_ready) begin if (q.size() != 0) void'(q.pop_front()); got++; end
      end
      if (in_valid && in_ready) begin q.push_back(model(a, b, cin)); idx++; end
    end
    in_valid = 1'b0;
    checks++; if (got !== 8) $display("FAIL stall_count: got %0d expected 8", got); else passes++;
  endtask

  task automatic test_reset_midstream();
    int lat;
    int stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'hAAAA + 16'(i); b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (outs !== 18'd0) $display("FAIL midrst_outputs: got %h expected 0", outs); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (out_valid) stale++; end
    checks++; if (stale !== 0) $display("FAIL midrst_stale: got %0d expected 0", stale); else passes++;
    a = 16'h00FF; b = 16'h0F01; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 4) $display("FAIL midrst_latency: got %0d expected 4", lat); else passes++;
    checks++; if (outs !== {1'b0, 1'b0, 16'h1000}) $display("FAIL midrst_result: got %h expected 01000", outs); else passes++;
  endtask

  task automatic test_random();
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    q.delete();
    while (got < 10000 && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 9) < 7);
      if (sent < 10000 && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
      end else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || outs !== q[0]) $display("FAIL random_result[%0d]: got %h expected %h", got, outs, (q.size() != 0) ? q[0] : 18'h0);
        else passes++;
        if (out_ready) begin if (q.size() != 0) void'(q.pop_front()); got++; end
      end
      if (in_valid && in_ready) begin q.push_back(model(a, b, cin)); sent++; end
    end
    in_valid = 1'b0;
    checks++; if (got !== 10000) $display("FAIL random_count: got %0d expected 10000", got); else passes++;
    checks++; if (q.size() !== 0) $display("FAIL random_leftover: got %0d expected 0", q.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
